// File: rtl/arb_pkg.sv
// Shared types and a reference round-robin scan for the rr_mux_arbiter block.
package arb_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_SEL_W = 4;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Scan ptr, ptr+1, ... (mod n) and return {found, idx} of the first set bit.
    function automatic logic [MAX_SEL_W:0] rr_pick(input logic [MAX_REQ-1:0]   valid,
                                                   input logic [MAX_SEL_W-1:0] ptr,
                                                   input int unsigned          n);
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
        logic [MAX_SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            cand = MAX_SEL_W'((32'(ptr) + i) % n);
            if (!found && (i < n) && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and downstream valid/ready channel of the round-robin mux arbiter.
interface rr_mux_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DWIDTH = 32
);
    localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  req_valid;
    logic [DWIDTH-1:0] req_data [N_REQ];
    logic [N_REQ-1:0]  req_ready;
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_ready;
    logic [SEL_W-1:0]  sel;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, sel
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, sel
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: rotate by ptr, find the lowest set bit, un-rotate.
module rr_priority_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [N_REQ-1:0] mask,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    localparam int unsigned SUM_W = SEL_W + 1;

    logic [N_REQ-1:0]   masked;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;
    logic [SUM_W-1:0]   sum;

    always_comb begin
        masked = valid & ~mask;
        dbl    = {masked, masked} >> ptr;
        rot    = dbl[N_REQ-1:0];
        found  = |rot;
        off    = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
        idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one downstream valid/ready channel between N_REQ requesters.
// Define RR_MUX_ARBITER_SVA_EN (with SIM undefined) to compile in embedded properties.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DWIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.master bus
);
    localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [SEL_W-1:0]  gnt_idx, gnt_nxt;
    logic              out_valid_q;
    logic [SEL_W-1:0]  ptr_inc;
    logic [N_REQ-1:0]  gnt_oh;
    logic [SEL_W-1:0]  pick_ptr;
    logic [N_REQ-1:0]  pick_mask;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [DWIDTH-1:0] mux_data;
    logic              xfer;

    assign ptr_inc = (gnt_idx == SEL_W'(N_REQ - 1)) ? '0 : gnt_idx + SEL_W'(1);
    assign gnt_oh  = N_REQ'(1) << gnt_idx;
    assign xfer    = out_valid_q && bus.out_ready;

    // In BUSY the picker looks ahead past the current grant so a hit can follow back-to-back.
    assign pick_ptr  = (state == BUSY) ? ptr_inc : ptr;
    assign pick_mask = (state == BUSY) ? gnt_oh : '0;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .valid (bus.req_valid),
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_idx     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gnt_idx     <= gnt_nxt;
            out_valid_q <= (state_nxt == BUSY);
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_idx;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nxt   = pick_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    ptr_nxt = ptr_inc;
                    if (pick_found) gnt_nxt   = pick_idx;
                    else            state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mux_data      = bus.req_data[gnt_idx];
    assign bus.out_data  = mux_data;
    assign bus.out_valid = out_valid_q;
    assign bus.sel       = gnt_idx;
    assign bus.req_ready = out_valid_q ? (gnt_oh & {N_REQ{bus.out_ready}}) : '0;

`ifdef RR_MUX_ARBITER_SVA_EN
`ifndef SIM
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));
    a_ready_implies: assert property (@(posedge clk) disable iff (!rst_n)
        (|bus.req_ready) |-> (bus.out_valid && bus.out_ready));
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> ($stable(bus.sel) && $stable(bus.out_data)));
    a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid |-> bus.req_valid[bus.sel]);
    a_sel_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(bus.sel) < N_REQ);

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_sva
        a_live: assert property (@(posedge clk) disable iff (!rst_n)
            bus.req_valid[i] |-> s_eventually bus.req_ready[i]);
        c_grant: cover property (@(posedge clk) disable iff (!rst_n)
            bus.req_ready[i]);
    end

    c_back2back: cover property (@(posedge clk) disable iff (!rst_n) xfer ##1 xfer);
    c_ptr_wrap: cover property (@(posedge clk) disable iff (!rst_n)
        xfer && (gnt_idx == SEL_W'(N_REQ - 1)));
`endif
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with N_REQ=4: grant order, backpressure, reset, fairness.
module tb_rr_mux_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DWIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errs;

    rr_mux_arbiter_if #(.N_REQ(N_REQ), .DWIDTH(DWIDTH)) bus ();

    rr_mux_arbiter #(
        .N_REQ  (N_REQ),
        .DWIDTH (DWIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full clock: exactly one rising edge passes, then we sit at the falling edge.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [1:0] s,
                           input logic [3:0] rr);
        #1;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(rr));
        if (ov) begin
            chk({tag, "_sel"}, 32'(bus.sel), 32'(s));
            chk({tag, "_data"}, bus.out_data, 32'hA000_0000 + 32'(s));
        end
    endtask

    int unsigned wait_cnt;
    int unsigned max_wait;
    int unsigned zero_grants;
    logic [3:0]  exp_order [5];
    logic [3:0]  rv;

    initial begin
        n_checks = 0;
        n_errs   = 0;
        for (int i = 0; i < int'(N_REQ); i++) bus.req_data[i] = 32'hA000_0000 + 32'(i);
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset holds everything quiet even with requests and ready present.
        nxt(); nxt();
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        bus.req_valid = 4'b0000;
        rst_n         = 1'b1;

        // Single request on idx 2: one-cycle latency, then back to IDLE with ptr=3.
        bus.req_valid = 4'b0100;
        nxt();
        chk_out("single", 1'b1, 2'd2, 4'b0100);
        nxt();
        bus.req_valid = 4'b0000;
        chk_out("single_idle", 1'b0, 2'd0, 4'b0000);

        // Only req 3 from ptr=3: grant, bubble, regrant.
        bus.req_valid = 4'b1000;
        nxt();
        chk_out("wrap_g1", 1'b1, 2'd3, 4'b1000);
        nxt();
        chk_out("wrap_bubble", 1'b0, 2'd0, 4'b0000);
        nxt();
        chk_out("wrap_g2", 1'b1, 2'd3, 4'b1000);
        nxt();
        bus.req_valid = 4'b0000;
        chk_out("wrap_idle", 1'b0, 2'd0, 4'b0000);

        // All requesting from ptr=0: 0,1,2,3,0 without bubbles.
        exp_order[0] = 4'd0; exp_order[1] = 4'd1; exp_order[2] = 4'd2;
        exp_order[3] = 4'd3; exp_order[4] = 4'd0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            nxt();
            chk_out($sformatf("all_%0d", k), 1'b1, exp_order[k][1:0], 4'b0001 << exp_order[k]);
        end

        // Backpressure on idx 1 for five cycles.
        nxt();
        bus.out_ready = 1'b0;
        chk_out("bp_0", 1'b1, 2'd1, 4'b0000);
        for (int k = 1; k < 5; k++) begin
            nxt();
            chk_out($sformatf("bp_%0d", k), 1'b1, 2'd1, 4'b0000);
        end
        bus.out_ready = 1'b1;
        chk_out("bp_release", 1'b1, 2'd1, 4'b0010);
        nxt();
        chk_out("bp_next", 1'b1, 2'd2, 4'b0100);

        // Async reset between edges while BUSY.
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'd0);
        chk("arst_sel", 32'(bus.sel), 32'd0);
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b1;
        nxt();
        chk_out("arst_hold", 1'b0, 2'd0, 4'b0000);
        rst_n = 1'b1;
        nxt();
        chk_out("arst_g1", 1'b1, 2'd1, 4'b0010);
        nxt();
        chk_out("arst_g2", 1'b1, 2'd3, 4'b1000);

        // Fairness: req 0 always on, others random, random downstream ready.
        wait_cnt    = 0;
        max_wait    = 0;
        zero_grants = 0;
        for (int k = 0; k < 1000; k++) begin
            nxt();
            rv = 4'($urandom_range(0, 15)) | 4'b0001;
            if (bus.out_valid) rv = rv | (4'b0001 << bus.sel);
            bus.req_valid = rv;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (bus.sel == 2'd0) begin
                    zero_grants++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt > max_wait) max_wait = wait_cnt;
                end
            end
        end
        chk("fair_max_wait_ok", 32'(max_wait <= 3), 32'd1);
        chk("fair_req0_served", 32'(zero_grants >= 50), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready channel between N_REQ requesters.
- Drives the select of the shared N-input datapath mux and returns per-requester ready.
- Sits in front of any shared processor resource, such as a memory port or writeback bus.
- Guarantees starvation freedom and never changes the grant while a transfer is pending.

Parameters:
- N_REQ, 4, number of requesters (1..16).
- DWIDTH, 32, width of each requester data word.
- SEL_W, derived: max(1, $clog2(N_REQ)), width of the select and grant index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  DWIDTH x N_REQ (unpacked array)  per-requester data.
- req_ready  out  N_REQ  one-hot acceptance, asserted only for the granted requester.
- out_valid  out  1  downstream valid.
- out_data  out  DWIDTH  equals req_data[sel].
- out_ready  in  1  downstream ready.
- sel  out  SEL_W  mux select; meaningful only while out_valid=1.

Behaviour:
- Reset (async assert, sync-style release on next clk edge):
  - state=IDLE, ptr=0, gnt_idx=0.
  - out_valid=0, req_ready=0, sel=0.
- States (arb_state_t): IDLE, BUSY.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning ptr, ptr+1, ... with wrap at N_REQ.
  - Register the pick into gnt_idx and go to BUSY.
  - Otherwise stay in IDLE.
  - Latency: a request arriving in IDLE produces out_valid on the next cycle.
- BUSY:
  - Outputs: out_valid=1, sel=gnt_idx, out_data=req_data[gnt_idx] (combinational mux), req_ready[gnt_idx]=out_ready, all other req_ready bits 0.
  - Transfer occurs when out_valid && out_ready.
  - No transfer: hold gnt_idx, sel and out_data. The grant never switches while a transfer is pending.
  - On transfer:
    - ptr <= gnt_idx+1, wrapping to 0 after N_REQ-1.
    - Re-arbitrate in the same cycle over req_valid with bit gnt_idx masked, scanning from the new ptr.
    - Hit: gnt_idx <= winner, stay in BUSY (back-to-back, 1 transfer/cycle).
    - Miss: go to IDLE, which gives one bubble before the same requester can be regranted.
- Requester rule: req_valid must stay high with stable data until req_ready. Dropping valid while granted is a protocol violation; behaviour is undefined and the SVA flags it.
- Fairness: a continuously held request is granted within N_REQ-1 transfers of other requesters.
- N_REQ=1: masking always misses, so the block alternates BUSY and IDLE (max 1 transfer per 2 cycles).
- Reset mid-transfer: the transfer is dropped; the requester's valid persists and it is re-arbitrated from ptr=0.
- Combinational paths: out_ready->req_ready and req_data->out_data. There is no path from req_valid to out_valid.

Optional Feature:
- Macro: RR_MUX_ARBITER_SVA_EN.
- Defined (and SIM undefined): embedded properties are compiled in:
  - at most one req_ready bit is set;
  - req_ready implies out_valid and out_ready;
  - out_valid && !out_ready holds sel and out_data stable into the next cycle;
  - granted req_valid stays high until its transfer;
  - sel < N_REQ;
  - liveness: req_valid[i] held implies eventually req_ready[i];
  - covers: a grant to each i, back-to-back grants, and a ptr wrap.
- Undefined: no assertion logic; RTL behaviour is identical.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - function rr_pick(valid, ptr), returning {found, idx}.
- One sub-module, rr_priority_pick:
  - combinational rotate, priority encode, un-rotate;
  - instantiated once, with its mask input fed from IDLE or BUSY as appropriate.
- The data mux is inline (or reuses the existing N-input mux).

Test Plan:
- Single request: reset, req_valid=4'b0100, out_ready=1.
  - Next cycle: out_valid=1, sel=2, req_ready=4'b0100.
  - Then IDLE with ptr=3.
- All requesting: req_valid=4'b1111, out_ready=1 held.
  - Grant order 0,1,2,3,0 on consecutive cycles, no bubbles.
- Backpressure: granted idx 1, out_ready=0 for 5 cycles.
  - sel=1 and out_data stable, req_ready=0 throughout.
  - Transfer on the cycle out_ready=1.
- Wrap and mask: ptr=3, only req 3 valid.
  - After transfer: IDLE for 1 cycle, then regrant idx 3.
- Async reset: assert rst_n=0 mid-BUSY between clock edges.
  - out_valid, req_ready and sel go to 0 immediately.
  - After release with req_valid=4'b1010: first grant is idx 1.
- Fairness: req 0 always valid, others random, 1000 cycles.
  - Req 0 is never waiting for more than 3 transfers.
